// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int WDOG_W          = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } fetch_state_e;

  // States in which a read is outstanding on the memory bus.
  function automatic logic is_waiting(input fetch_state_e s);
    return (s == S_REQ) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of PC, memory-read and decode handshake signals around the fetch stage.
interface fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc;
  logic              pc_en;
  logic              flush;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_rd_ack;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              fetch_err;

  modport master (
    input  pc, flush, mem_rd_ack, mem_rd_data, ir_ready,
    output pc_en, mem_addr, mem_rd_req, ir, ir_pc, ir_valid, fetch_err
  );

  modport slave (
    output pc, flush, mem_rd_ack, mem_rd_data, ir_ready,
    input  pc_en, mem_addr, mem_rd_req, ir, ir_pc, ir_valid, fetch_err
  );
endinterface

// File: rtl/fetch_wdog.sv
// Saturating wait counter for the fetch read handshake; expires at TIMEOUT_CYC.
module fetch_wdog
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  logic [WDOG_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt >= WDOG_W'(TIMEOUT_CYC));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory read, IR hold, PC advance and flush.
// Optional read timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd_req;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_ir_valid;
  logic              r_inc;
  logic              r_fetch_err;
  logic              w_expired;

`ifdef FETCH_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_en;

  // Restart the count whenever a fresh wait begins (IDLE->REQ or REQ->DRAIN).
  assign w_wd_clear = ((r_state == S_IDLE) && !bus.flush) ||
                      ((r_state == S_REQ) && bus.flush && !bus.mem_rd_ack && !w_expired);
  assign w_wd_en    = is_waiting(r_state) && !bus.mem_rd_ack;

  fetch_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_mem_rd_req <= 1'b0;
      r_ir         <= '0;
      r_ir_pc      <= '0;
      r_ir_valid   <= 1'b0;
      r_inc        <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_inc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // On flush the PC is loading a target; sample it next cycle instead.
          if (!bus.flush) begin
            r_mem_addr   <= bus.pc;
            r_mem_rd_req <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_rd_ack) begin
            r_mem_rd_req <= 1'b0;
            if (bus.flush) begin
              r_state <= S_IDLE;
            end else begin
              r_ir       <= bus.mem_rd_data;
              r_ir_pc    <= r_mem_addr;
              r_ir_valid <= 1'b1;
              r_inc      <= 1'b1;
              r_state    <= S_HOLD;
            end
          end else if (w_expired) begin
            r_mem_rd_req <= 1'b0;
            r_fetch_err  <= 1'b1;
            r_state      <= S_ERR;
          end else if (bus.flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (bus.flush || bus.ir_ready) begin
            r_ir_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // The bus read cannot be cancelled; swallow its data when it lands.
          if (bus.mem_rd_ack) begin
            r_mem_rd_req <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_expired) begin
            r_mem_rd_req <= 1'b0;
            r_fetch_err  <= 1'b1;
            r_state      <= S_ERR;
          end
        end
        S_ERR: begin
          r_mem_rd_req <= 1'b0;
          r_ir_valid   <= 1'b0;
          r_fetch_err  <= 1'b1;
        end
        default: begin
          r_mem_rd_req <= 1'b0;
          r_ir_valid   <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pc_en      = r_inc | bus.flush;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_rd_req = r_mem_rd_req;
  assign bus.ir         = r_ir;
  assign bus.ir_pc      = r_ir_pc;
  assign bus.ir_valid   = r_ir_valid;
  assign bus.fetch_err  = r_fetch_err;

endmodule
